// File: rtl/free_list_pkg.sv
// Purpose: shared types, sizing helpers and lane-counting functions for the free list.
// Latency: n/a (package, pure functions only).
// Backpressure: n/a.
package free_list_pkg;

    localparam int NUM_PREG_DEF = 32;
    localparam int NUM_ARCH_DEF = 16;
    localparam int NUM_CKPT_DEF = 4;
    localparam int TAG_W_DEF    = $clog2(NUM_PREG_DEF);
    // Widest lane vector the counting helpers accept; narrower vectors are zero-extended.
    localparam int MAX_LANES    = 16;

    typedef logic [TAG_W_DEF-1:0]            tag_t;
    typedef logic [$clog2(NUM_CKPT_DEF)-1:0] ckpt_id_t;

    // Entries in the circular list: every tag not mapped at reset.
    function automatic int cap_of(input int num_preg, input int num_arch);
        return num_preg - num_arch;
    endfunction

    localparam int CAP_DEF = cap_of(NUM_PREG_DEF, NUM_ARCH_DEF);

    // Number of set bits strictly below position lane.
    function automatic int prefix_count(input logic [MAX_LANES-1:0] v, input int lane);
        int c;
        c = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < lane && v[i]) c++;
        end
        return c;
    endfunction

    function automatic int popcount(input logic [MAX_LANES-1:0] v);
        return prefix_count(v, MAX_LANES);
    endfunction

endpackage

// File: rtl/free_list_mp_lane_compactor.sv
// Purpose: map a per-lane valid vector to packed offsets (lane-order prefix sum) and a total.
// Latency: combinational.
// Backpressure: none; pure mapping.
// Ports: vld (per-lane valid) -> ofs (offset of each lane among valid lanes), total (popcount).
module lane_compactor #(
    parameter int W     = 2,
    parameter int OFS_W = $clog2(W + 1)
) (
    input  logic [W-1:0]            vld,
    output logic [W-1:0][OFS_W-1:0] ofs,
    output logic [OFS_W-1:0]        total
);
    import free_list_pkg::*;

    logic [MAX_LANES-1:0] vld_ext;

    assign vld_ext = MAX_LANES'(vld);

    always_comb begin
        ofs = '0;
        for (int i = 0; i < W; i++) begin
            ofs[i] = OFS_W'(prefix_count(vld_ext, i));
        end
    end

    assign total = OFS_W'(popcount(vld_ext));

endmodule

// File: rtl/free_list_mp.sv
// Purpose: multi-port physical-register free list with head-pointer checkpoints for mispredict recovery.
// Latency: tags granted combinationally in the request cycle; checked-in tags usable from the next cycle.
// Backpressure: all-or-nothing alloc_ready stalls rename; checkins beyond capacity are dropped and flagged.
// Ports: alloc_req/alloc_ready/alloc_tag (rename side), free_valid/free_tag (commit side),
//        ckpt_save(_id)/ckpt_restore(_id) (branch recovery), free_count, overflow_err (sticky).
module free_list_mp #(
    parameter int NUM_PREG = 32,
    parameter int NUM_ARCH = 16,
    parameter int ALLOC_W  = 2,
    parameter int FREE_W   = 2,
    parameter int NUM_CKPT = 4,
    parameter int TAG_W    = $clog2(NUM_PREG)
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic [ALLOC_W-1:0]              alloc_req,
    output logic                            alloc_ready,
    output logic [ALLOC_W-1:0][TAG_W-1:0]   alloc_tag,
    input  logic [FREE_W-1:0]               free_valid,
    input  logic [FREE_W-1:0][TAG_W-1:0]    free_tag,
    input  logic                            ckpt_save,
    input  logic [$clog2(NUM_CKPT)-1:0]     ckpt_save_id,
    input  logic                            ckpt_restore,
    input  logic [$clog2(NUM_CKPT)-1:0]     ckpt_restore_id,
    output logic [$clog2(NUM_PREG+1)-1:0]   free_count,
    output logic                            overflow_err
);
    import free_list_pkg::*;

    localparam int CAP    = cap_of(NUM_PREG, NUM_ARCH);
    // Pointers run over 0..2*CAP-1; the extra range separates full from empty.
    localparam int PTR_W  = $clog2(2 * CAP);
    localparam int IDX_W  = $clog2(CAP);
    localparam int AOFS_W = $clog2(ALLOC_W + 1);
    localparam int FOFS_W = $clog2(FREE_W + 1);
    localparam int CNT_W  = $clog2(NUM_PREG + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    function automatic ptr_t ptr_add(input ptr_t p, input int d);
        int s;
        s = int'(p) + d;
        if (s >= 2 * CAP) s = s - 2 * CAP;
        return ptr_t'(s);
    endfunction

    function automatic logic [IDX_W-1:0] ptr_idx(input ptr_t p);
        int s;
        s = int'(p);
        if (s >= CAP) s = s - CAP;
        return IDX_W'(s);
    endfunction

    ptr_t             head, tail, head_nxt, tail_nxt;
    ptr_t             ckpt [NUM_CKPT];
    logic [TAG_W-1:0] mem  [CAP];

    logic [ALLOC_W-1:0][AOFS_W-1:0] alloc_ofs;
    logic [AOFS_W-1:0]              alloc_n;
    logic [FREE_W-1:0][FOFS_W-1:0]  free_ofs;
    logic [FREE_W-1:0]              free_acc;
    logic [FOFS_W-1:0]              free_n;
    int                             free_acc_n;
    int                             count;
    int                             room;
    logic                           ovf_now;

    lane_compactor #(.W(ALLOC_W), .OFS_W(AOFS_W)) u_alloc_cmp (
        .vld   (alloc_req),
        .ofs   (alloc_ofs),
        .total (alloc_n)
    );

    lane_compactor #(.W(FREE_W), .OFS_W(FOFS_W)) u_free_cmp (
        .vld   (free_valid),
        .ofs   (free_ofs),
        .total (free_n)
    );

    always_comb begin
        count = int'(tail) - int'(head);
        if (count < 0) count = count + 2 * CAP;
        room = CAP - count;
    end

    assign free_count  = CNT_W'(count);
    assign alloc_ready = (count >= int'(alloc_n)) && !ckpt_restore;

    // Lanes without a grant read zero so downstream never sees stale tags.
    always_comb begin
        alloc_tag = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            if (alloc_req[i] && alloc_ready) begin
                alloc_tag[i] = mem[ptr_idx(ptr_add(head, int'(alloc_ofs[i])))];
            end
        end
    end

    // Room is judged on the pre-edge count; same-cycle grants are not credited,
    // so a checkin can never land on an entry still visible to rename.
    always_comb begin
        free_acc   = '0;
        free_acc_n = 0;
        for (int j = 0; j < FREE_W; j++) begin
            if (free_valid[j] && int'(free_ofs[j]) < room) begin
                free_acc[j] = 1'b1;
                free_acc_n  = free_acc_n + 1;
            end
        end
    end

    assign ovf_now = int'(free_n) > room;

    always_comb begin
        head_nxt = head;
        if (ckpt_restore)     head_nxt = ckpt[ckpt_restore_id];
        else if (alloc_ready) head_nxt = ptr_add(head, int'(alloc_n));
    end

    assign tail_nxt = ptr_add(tail, free_acc_n);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            head         <= '0;
            tail         <= ptr_t'(CAP);
            overflow_err <= 1'b0;
            for (int k = 0; k < NUM_CKPT; k++) ckpt[k] <= '0;
            for (int i = 0; i < CAP; i++)      mem[i]  <= TAG_W'(NUM_ARCH + i);
        end else begin
            head <= head_nxt;
            tail <= tail_nxt;
            if (ovf_now)   overflow_err <= 1'b1;
            // Saving alongside a restore captures the restored head, since head_nxt already reflects it.
            if (ckpt_save) ckpt[ckpt_save_id] <= head_nxt;
            for (int j = 0; j < FREE_W; j++) begin
                if (free_acc[j]) mem[ptr_idx(ptr_add(tail, int'(free_ofs[j])))] <= free_tag[j];
            end
        end
    end

    always @(posedge clk) begin
        if (n_rst) begin
            assert (!ovf_now)
                else $warning("free_list_mp: checkin beyond capacity, excess lanes dropped");
        end
    end

endmodule

// File: tb/tb_free_list_mp.sv
// Purpose: self-checking bench for free_list_mp: vector table, directed corner sequences, random vs queue model.
// Latency: inputs driven at negedge, outputs sampled 2 time units later, state advances at posedge.
// Backpressure: model predicts alloc_ready stalls and dropped checkins.
module tb_free_list_mp;
    localparam int CAP = 16;

    logic             clk;
    logic             n_rst;
    logic [1:0]       alloc_req;
    logic             alloc_ready;
    logic [1:0][4:0]  alloc_tag;
    logic [1:0]       free_valid;
    logic [1:0][4:0]  free_tag;
    logic             ckpt_save;
    logic [1:0]       ckpt_save_id;
    logic             ckpt_restore;
    logic [1:0]       ckpt_restore_id;
    logic [5:0]       free_count;
    logic             overflow_err;

    free_list_mp dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .alloc_req       (alloc_req),
        .alloc_ready     (alloc_ready),
        .alloc_tag       (alloc_tag),
        .free_valid      (free_valid),
        .free_tag        (free_tag),
        .ckpt_save       (ckpt_save),
        .ckpt_save_id    (ckpt_save_id),
        .ckpt_restore    (ckpt_restore),
        .ckpt_restore_id (ckpt_restore_id),
        .free_count      (free_count),
        .overflow_err    (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: an unbounded log of every tag ever placed in the list,
    // with absolute (never wrapping) head/tail positions into it.
    int mlog[$];
    int m_head, m_tail;
    int m_ckpt[4];
    int m_ovf;

    int obs_rdy, obs_t0, obs_t1, obs_fc, obs_ovf;

    typedef struct {
        bit         rst;
        int         rep;
        logic [1:0] req;
        logic [1:0] fv;
        logic [4:0] ft0;
        int         e_rdy;
        int         e_t0;
        int         e_t1;
        int         e_fc;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int bits2(input logic [1:0] v);
        return int'(v[0]) + int'(v[1]);
    endfunction

    task automatic model_reset();
        mlog.delete();
        for (int i = 0; i < CAP; i++) mlog.push_back(16 + i);
        m_head = 0;
        m_tail = CAP;
        for (int k = 0; k < 4; k++) m_ckpt[k] = 0;
        m_ovf = 0;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        alloc_req = '0; free_valid = '0; free_tag = '0;
        ckpt_save = 1'b0; ckpt_save_id = '0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
        #3;
        n_rst = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic [1:0] req, input logic [1:0] fv,
                        input logic [4:0] ft0, input logic [4:0] ft1,
                        input logic sv, input logic [1:0] sid,
                        input logic rs, input logic [1:0] rid);
        int n, cnt, room, k, acc, hn;
        bit exp_rdy;
        alloc_req = req; free_valid = fv; free_tag[0] = ft0; free_tag[1] = ft1;
        ckpt_save = sv; ckpt_save_id = sid; ckpt_restore = rs; ckpt_restore_id = rid;
        #2;
        obs_rdy = int'(alloc_ready); obs_t0 = int'(alloc_tag[0]); obs_t1 = int'(alloc_tag[1]);
        obs_fc = int'(free_count);   obs_ovf = int'(overflow_err);
        n   = bits2(req);
        cnt = m_tail - m_head;
        exp_rdy = (cnt >= n) && !rs;
        chk("alloc_ready", obs_rdy, int'(exp_rdy));
        chk("free_count", obs_fc, cnt);
        chk("overflow_err", obs_ovf, m_ovf);
        k = 0;
        for (int i = 0; i < 2; i++) begin
            if (!req[i]) chk($sformatf("idle_tag%0d", i), int'(alloc_tag[i]), 0);
            else if (exp_rdy) begin
                chk($sformatf("alloc_tag%0d", i), int'(alloc_tag[i]), mlog[m_head + k]);
                k++;
            end
        end
        @(posedge clk);
        room = CAP - cnt;
        acc = 0;
        if (fv[0]) begin if (acc < room) begin mlog.push_back(int'(ft0)); m_tail++; end acc++; end
        if (fv[1]) begin if (acc < room) begin mlog.push_back(int'(ft1)); m_tail++; end acc++; end
        if (acc > room) m_ovf = 1;
        hn = rs ? m_ckpt[rid] : (exp_rdy ? m_head + n : m_head);
        if (sv) m_ckpt[sid] = hn;
        m_head = hn;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] req, fv;
        logic       sv, rs;
        logic [1:0] sid, rid;
        int         tn;

        n_rst = 1'b0;
        alloc_req = '0; free_valid = '0; free_tag = '0;
        ckpt_save = 1'b0; ckpt_save_id = '0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
        repeat (2) @(negedge clk);

        //            rst rep req    fv     ft0    rdy t0  t1  fc
        vecs[0] = '{1'b1, 1, 2'b11, 2'b00, 5'd0,  1, 16, 17, 16};
        vecs[1] = '{1'b0, 1, 2'b00, 2'b00, 5'd0,  1,  0,  0, 14};
        vecs[2] = '{1'b1, 1, 2'b10, 2'b00, 5'd0,  1,  0, 16, 16};
        vecs[3] = '{1'b0, 1, 2'b00, 2'b00, 5'd0,  1,  0,  0, 15};
        vecs[4] = '{1'b0, 7, 2'b11, 2'b00, 5'd0,  1, -1, -1,  3};
        vecs[5] = '{1'b0, 1, 2'b11, 2'b00, 5'd0,  0, -1, -1,  1};
        vecs[6] = '{1'b0, 1, 2'b00, 2'b01, 5'd16, 1,  0,  0,  1};
        vecs[7] = '{1'b0, 1, 2'b11, 2'b00, 5'd0,  1, 31, 16,  2};
        vecs[8] = '{1'b0, 1, 2'b00, 2'b00, 5'd0,  1,  0,  0,  0};

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].rst) do_reset();
            for (int r = 0; r < vecs[v].rep; r++)
                step(vecs[v].req, vecs[v].fv, vecs[v].ft0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0);
            if (vecs[v].e_rdy >= 0) chk($sformatf("vec%0d_ready", v), obs_rdy, vecs[v].e_rdy);
            if (vecs[v].e_t0 >= 0)  chk($sformatf("vec%0d_tag0", v),  obs_t0,  vecs[v].e_t0);
            if (vecs[v].e_t1 >= 0)  chk($sformatf("vec%0d_tag1", v),  obs_t1,  vecs[v].e_t1);
            if (vecs[v].e_fc >= 0)  chk($sformatf("vec%0d_fc", v),    obs_fc,  vecs[v].e_fc);
        end

        // Checkpoint/restore with a simultaneous checkin, then wrap-around.
        do_reset();
        step(2'b11, 2'b00, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        step(2'b11, 2'b00, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        step(2'b00, 2'b00, 5'd0, 5'd0, 1'b1, 2'd2, 1'b0, 2'd0);
        chk("save_fc", obs_fc, 12);
        repeat (3) step(2'b11, 2'b00, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        step(2'b11, 2'b01, 5'd5, 5'd0, 1'b0, 2'd0, 1'b1, 2'd2);
        chk("restore_blocks_alloc", obs_rdy, 0);
        chk("restore_fc_pre", obs_fc, 6);
        step(2'b01, 2'b00, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        chk("post_restore_ready", obs_rdy, 1);
        chk("post_restore_tag", obs_t0, 20);
        chk("post_restore_fc", obs_fc, CAP - 4 + 1);
        for (int c = 0; c < 40; c++) begin
            step(2'b01, 2'b01, 5'($urandom_range(0, 31)), 5'd0, 1'b0, 2'd0, 1'b0, 2'd0);
            chk("wrap_fc_const", obs_fc, 12);
        end

        // Overflow stickiness and asynchronous reset.
        do_reset();
        step(2'b00, 2'b01, 5'd3, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        step(2'b00, 2'b00, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        chk("ovf_set", obs_ovf, 1);
        chk("ovf_dropped_fc", obs_fc, 16);
        step(2'b11, 2'b00, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        chk("ovf_no_overwrite", obs_t0, 16);
        step(2'b00, 2'b00, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        chk("ovf_sticky", obs_ovf, 1);
        chk("ovf_fc14", obs_fc, 14);
        alloc_req = 2'b11;
        n_rst = 1'b0;
        #1;
        chk("async_rst_fc", int'(free_count), 16);
        chk("async_rst_ovf", int'(overflow_err), 0);
        chk("async_rst_tag0", int'(alloc_tag[0]), 16);
        alloc_req = 2'b00;
        #2;
        n_rst = 1'b1;
        model_reset();
        @(negedge clk);

        // Random traffic against the model; frees limited to available room,
        // restores only to checkpoints whose entries are still intact.
        for (int c = 0; c < 1500; c++) begin
            req = 2'($urandom);
            fv  = 2'($urandom);
            while (bits2(fv) > CAP - (m_tail - m_head)) fv = fv & (fv - 2'd1);
            sv  = ($urandom_range(0, 5) == 0);
            sid = 2'($urandom);
            rid = 2'($urandom);
            rs  = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                tn = m_tail + bits2(fv);
                if (tn - m_ckpt[rid] >= 0 && tn - m_ckpt[rid] <= CAP) rs = 1'b1;
            end
            step(req, fv, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), sv, sid, rs, rid);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/free_list_mp.md
Name: free_list_mp

Overview:
Multi-port physical-register free list for the out-of-order core. It is the parametrised successor of the single-port free register list.
- Hands out up to ALLOC_W physical tags per cycle to rename.
- Accepts up to FREE_W retired tags per cycle from the commit unit.
- Holds NUM_CKPT head-pointer checkpoints so a branch mispredict restores all speculatively allocated tags in one cycle.

Parameters:
NUM_PREG, 32, number of physical registers (power of two)
NUM_ARCH, 16, architectural registers; tags 0..NUM_ARCH-1 are mapped at reset, never in list initially
ALLOC_W, 2, allocation lanes per cycle
FREE_W, 2, checkin lanes per cycle
NUM_CKPT, 4, checkpoint slots
TAG_W, $clog2(NUM_PREG), tag width (derived)

Ports:
clk  in  1  clock
n_rst  in  1  async active-low reset
alloc_req  in  ALLOC_W  per-lane tag request
alloc_ready  out  1  all asserted requests granted this cycle (all-or-nothing)
alloc_tag  out  ALLOC_W x TAG_W  tag per lane, valid when lane requested and alloc_ready
free_valid  in  FREE_W  per-lane checkin valid
free_tag  in  FREE_W x TAG_W  tag returned per lane
ckpt_save  in  1  snapshot current head (post-allocation value) into slot
ckpt_save_id  in  $clog2(NUM_CKPT)  slot to write
ckpt_restore  in  1  roll head back to slot
ckpt_restore_id  in  $clog2(NUM_CKPT)  slot to read
free_count  out  $clog2(NUM_PREG+1)  tags currently available
overflow_err  out  1  sticky: checkin would exceed capacity

Behaviour:
- Storage:
  - Circular array of NUM_PREG-NUM_ARCH entries, capacity CAP = NUM_PREG-NUM_ARCH.
  - head/tail pointers carry one extra wrap bit.
  - count = tail - head (modulo 2*CAP).
- Reset (async, n_rst=0):
  - entry i = NUM_ARCH+i; head=0, tail=CAP with wrap bit clear; count=CAP.
  - free_count=CAP, overflow_err=0, all checkpoints = 0.
  - Outputs read 0 on lanes with no request.
- Allocation:
  - Combinational, same cycle. n = popcount(alloc_req).
  - alloc_ready = (count >= n) && !ckpt_restore.
  - Requesting lane i receives entry at head+k, where k = number of requesting lanes below i (lane-order compaction).
  - On edge with alloc_ready && n>0: head += n.
  - If !alloc_ready: no lane granted, head unchanged (rename stalls).
  - n=0: alloc_ready=1.
- Checkin:
  - Valid lanes are packed in lane order and written at tail, tail+1, ...; tail += popcount(free_valid) at edge.
  - Tags checked in are not available to allocation until the next cycle; there is no bypass.
- Checkpoint save: slot[ckpt_save_id] <= head value after this cycle's allocation. Saving in the same cycle as a restore stores the restored head.
- Restore:
  - head <= slot[ckpt_restore_id] at edge; allocation blocked that cycle.
  - Checkins in the same cycle are still applied.
  - Restoring over in-flight frees is safe: entries between saved head and current head are never overwritten while count <= CAP.
- Wrap-around: pointer arithmetic mod CAP for indexing; the wrap bit distinguishes full (count=CAP) from empty (count=0).
- Overflow: if count + frees > CAP, excess lanes are dropped and overflow_err sets. It is cleared only by reset; a simulation assertion also fires.
- free_count is registered count (pre-edge value).

Decomposition:
- Package free_list_pkg holds:
  - tag_t typedef and CAP localparam function
  - ckpt_id_t typedef
  - popcount and prefix-count functions, shared with the future multi-port translation table
- One natural sub-module: lane_compactor. It is a prefix-sum mapping from a valid vector to packed offsets and is instantiated twice, once for alloc lanes and once for free lanes.

Test Plan:
- After reset, alloc_req=2'b11 -> alloc_ready=1, tags 16,17; next cycle free_count=14.
- alloc_req=2'b10 only -> lane1 gets tag 16, lane0 tag don't-care; head advances by 1.
- Drain to count=1, then alloc_req=2'b11 -> alloc_ready=0, head unchanged; then free_valid=2'b01, free_tag=16 -> next cycle count=2, alloc_ready=1.
- Save slot 2 at head=4, allocate 6 more tags (head=10), restore slot 2 with simultaneous checkin of tag 5 -> head=4, count=CAP-4+1, alloc_ready=0 that cycle, next alloc returns tag 20.
- Wrap: cycle 40 alloc/free pairs -> tags after 31 wrap back to recycled values, count stays constant, wrap bit toggles.
- At count=16, free_valid=2'b01 -> overflow_err=1 and stays 1 until n_rst pulse; n_rst asserted mid-allocation -> outputs reset immediately, without waiting for clk.
